ram_mr1w: RTL

RAM_MR1W -- requirements
Module: ram_mr1w

---
 rtl/ram_mr1w.sv | 115 +++++++++++
 1 files changed

// File: rtl/ram_mr1w.sv
// Single-write, multi-read synchronous RAM with byte enables and registered reads.
// Clears itself to zero after reset, one word per cycle, before accepting traffic.
module ram_mr1w #(
  parameter int DW     = 8,
  parameter int DEPTH  = 64,
  parameter int NUM_RD = 2,
  parameter int WR_FWD = 1,
  localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int NB    = DW / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic [NB-1:0]        wr_be,
  input  logic [NUM_RD-1:0]    rd_en,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_valid,
  output logic                 init_busy
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [AW-1:0]       init_cnt_q, init_cnt_d;
  logic [DW-1:0]       mem_q [DEPTH];
  logic [NUM_RD*DW-1:0] rd_data_q;
  logic [NUM_RD-1:0]   rd_valid_q;

  logic                wr_in_range;
  logic                wr_fire;
  logic [DW-1:0]       wr_old;
  logic [DW-1:0]       wr_merged;
  logic [AW-1:0]       rd_addr_w [NUM_RD];
  logic [DW-1:0]       rd_word   [NUM_RD];
  logic                rd_fire   [NUM_RD];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST) begin
        state_d    = READY;
        init_cnt_d = '0;
      end
    end
  end

  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    wr_fire     = (state_q == READY) && en && wr_en && wr_in_range;
    wr_old      = wr_in_range ? mem_q[wr_addr] : '0;
    wr_merged   = wr_old;
    for (int unsigned k = 0; k < NB; k++) begin
      if (wr_be[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
    end
  end

  // A forwarded read sees the merged word; otherwise the array still holds the pre-write value.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_addr_w[i] = rd_addr[i*AW +: AW];
      rd_fire[i]   = (state_q == READY) && en && rd_en[i];
      rd_word[i]   = '0;
      if ({1'b0, rd_addr_w[i]} < DEPTH_W) begin
        if ((WR_FWD != 0) && wr_fire && (rd_addr_w[i] == wr_addr)) rd_word[i] = wr_merged;
        else                                                        rd_word[i] = mem_q[rd_addr_w[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem_q[init_cnt_q] <= '0;
      end else if (wr_fire) begin
        mem_q[wr_addr] <= wr_merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        rd_valid_q[i] <= rd_fire[i];
        if (rd_fire[i]) rd_data_q[i*DW +: DW] <= rd_word[i];
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign init_busy = (state_q == INIT);

endmodule
